// File: rtl/shift_ser_ctrl_pkg.sv
// Shared definitions for the shift-register serializer: register mode codes,
// controller state encoding and the gap-timer width.
package shift_ser_ctrl_pkg;

    typedef enum logic [1:0] {
        MODO_SHIFT  = 2'b00,
        MODO_ROTATE = 2'b01,
        MODO_LOAD   = 2'b10,
        MODO_HOLD   = 2'b11
    } modo_t;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_PAR   = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // GAP ranges 0..15
    localparam int GAP_CW = 4;

endpackage

// File: rtl/shift_ser_ctrl_bit_cnt.sv
// Up-counter with synchronous clear/increment and a terminal flag against a
// programmable last value; serves both the bit count and the gap timer.
module shift_ser_ctrl_bit_cnt #(
    parameter int W = 3
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/shift_ser_ctrl.sv
// Sequencer for a 4-bit universal shift register: load a word, stream it out
// bit by bit over valid/ready. Define SHIFT_SER_PARITY_EN to append an even-parity bit.
//
// state | meaning
// CLR   | one cycle: parallel-load zeros, the register has no reset of its own
// IDLE  | REQ_READY high, waiting for a word
// LOAD  | one cycle: parallel-load the captured word
// SHIFT | present Q end bit, shift on each TX accept
// PAR   | present even parity of the word (parity build only)
// GAP   | GAP idle cycles, DONE on the first one
module shift_ser_ctrl
    import shift_ser_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] REQ_DATA,
    input  logic             REQ_DIR,
    output logic             TX_VALID,
    input  logic             TX_READY,
    output logic             TX_BIT,
    output logic             DONE,
    output logic             ENB,
    output logic [1:0]       MODO,
    output logic             DIR,
    output logic             S_IN,
    output logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q
);

    localparam int                CW            = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     BIT_LAST      = CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST      = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
    localparam state_t            ST_AFTER_WORD = (GAP == 0) ? ST_IDLE : ST_GAP;
    localparam logic [WIDTH-1:0]  MSB_MASK      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  LSB_MASK      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] data_r;
    logic             dir_r;
    logic             done_r;
    logic             bit_tc;
    logic             gap_tc;

    shift_ser_ctrl_bit_cnt #(.W(CW)) u_bit_cnt (
        .clk_sys (CLK),
        .rst     (RST),
        .clr     (state != ST_SHIFT),
        .inc     ((state == ST_SHIFT) && TX_READY),
        .last    (BIT_LAST),
        .tc      (bit_tc)
    );

    shift_ser_ctrl_bit_cnt #(.W(GAP_CW)) u_gap_cnt (
        .clk_sys (CLK),
        .rst     (RST),
        .clr     (state != ST_GAP),
        .inc     (state == ST_GAP),
        .last    (GAP_LAST),
        .tc      (gap_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_CLR;
            data_r <= '0;
            dir_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_CLR:  state <= ST_IDLE;
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        data_r <= REQ_DATA;
                        dir_r  <= REQ_DIR;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (TX_READY && bit_tc) begin
`ifdef SHIFT_SER_PARITY_EN
                        state  <= ST_PAR;
`else
                        done_r <= 1'b1;
                        state  <= ST_AFTER_WORD;
`endif
                    end
                end
`ifdef SHIFT_SER_PARITY_EN
                ST_PAR: begin
                    if (TX_READY) begin
                        done_r <= 1'b1;
                        state  <= ST_AFTER_WORD;
                    end
                end
`endif
                ST_GAP:  if (gap_tc) state <= ST_IDLE;
                default: state <= ST_CLR;
            endcase
        end
    end

    // Reset overrides the state decode so outputs are quiet from the first reset cycle
    always_comb begin
        REQ_READY = 1'b0;
        TX_VALID  = 1'b0;
        TX_BIT    = 1'b0;
        ENB       = 1'b0;
        MODO      = MODO_HOLD;
        DIR       = 1'b0;
        D         = '0;
        if (!RST) begin
            case (state)
                ST_CLR: begin
                    ENB  = 1'b1;
                    MODO = MODO_LOAD;
                end
                ST_IDLE: REQ_READY = 1'b1;
                ST_LOAD: begin
                    ENB  = 1'b1;
                    MODO = MODO_LOAD;
                    D    = data_r;
                end
                ST_SHIFT: begin
                    TX_VALID = 1'b1;
                    TX_BIT   = |(Q & (dir_r ? MSB_MASK : LSB_MASK));
                    DIR      = dir_r;
                    MODO     = MODO_SHIFT;
                    ENB      = TX_READY;
                end
`ifdef SHIFT_SER_PARITY_EN
                ST_PAR: begin
                    TX_VALID = 1'b1;
                    TX_BIT   = ^data_r;
                end
`endif
                default: ;
            endcase
        end
    end

    assign DONE = done_r & ~RST;
    assign S_IN = 1'b0;

endmodule
